// File: rtl/sm_cpu_mc_pkg.sv
`default_nettype none
// ============================================================================
// sm_cpu_mc_pkg : ISA constants, ALU op codes and FSM states for sm_cpu_mc
// Revision      : 1.0
// ============================================================================
package sm_cpu_mc_pkg;

    localparam logic [5:0] C_SPEC  = 6'b000000;
    localparam logic [5:0] C_ADDIU = 6'b001001;
    localparam logic [5:0] C_LUI   = 6'b001111;
    localparam logic [5:0] C_ANDI  = 6'b001100;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_BNE   = 6'b000101;
    localparam logic [5:0] C_BGEZ  = 6'b000001;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;

    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SUBU  = 6'b100011;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_AND  = 3'd2,
        ALU_LUI  = 3'd3,
        ALU_SRL  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_SUB  = 3'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_NOP    = 2'd0,
        K_BRANCH = 2'd1,
        K_MEM    = 2'd2,
        K_ALU    = 2'd3
    } ikind_t;

endpackage
`default_nettype wire

// File: rtl/sm_alu_v2.sv
`default_nettype none
// ============================================================================
// sm_alu_v2 : combinational ALU for sm_cpu_mc (add/sub/or/and/lui/srl/sltu)
// Revision  : 1.0
// ============================================================================
module sm_alu_v2
    import sm_cpu_mc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD:  result = srcA + srcB;
            ALU_OR:   result = srcA | srcB;
            ALU_AND:  result = srcA & srcB;
            ALU_LUI:  result = {srcB[15:0], 16'h0000};
            ALU_SRL:  result = srcB >> shamt;
            ALU_SLTU: result = {31'h0, (srcA < srcB)};
            ALU_SUB:  result = srcA - srcB;
            default:  result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule
`default_nettype wire

// File: rtl/sm_cpu_mc.sv
`default_nettype none
// ============================================================================
// sm_cpu_mc : multi-cycle schoolMIPS core with req/ack instruction/data ports.
//             Define SM_CPU_MC_INSTRET_EN to add the instRet counter port.
// Revision  : 1.0
// ============================================================================
module sm_cpu_mc
    import sm_cpu_mc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DATA_W   = 32,
    parameter int          RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic [31:0] imAddr,
    output logic        imReq,
    input  logic        imAck,
    input  logic [31:0] imData,
    output logic [31:0] dmAddr,
    output logic        dmReq,
    output logic        dmWe,
    output logic [31:0] dmWData,
    input  logic        dmAck,
    input  logic [31:0] dmRData,
    output logic [2:0]  cpuState
`ifdef SM_CPU_MC_INSTRET_EN
    ,
    output logic [31:0] instRet
`endif
);

    if (DATA_W != 32 || RF_DEPTH != 32) begin : g_bad_config
        $error("sm_cpu_mc supports only DATA_W=32 and RF_DEPTH=32");
    end

    state_t      state;
    logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rf [0:RF_DEPTH-1];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, zero_imm;
    ikind_t      kind;
    alu_op_t     alu_op;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        taken;
    logic        is_sw;
    logic [31:0] wb_data;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = {{16{ir[15]}}, ir[15:0]};
    assign zero_imm = {16'h0000, ir[15:0]};
    assign is_sw    = (opcode == C_SW);

    // Decoded fresh from IR every cycle, so shift source and extension never leak across instructions.
    always_comb begin
        kind   = K_NOP;
        alu_op = ALU_ADD;
        src_b  = b_reg;
        shamt  = ir[10:6];
        dest   = rt;
        case (opcode)
            C_SPEC: begin
                dest = rd;
                case (funct)
                    F_ADDU: begin kind = K_ALU; alu_op = ALU_ADD;  end
                    F_OR:   begin kind = K_ALU; alu_op = ALU_OR;   end
                    F_SRL:  begin kind = K_ALU; alu_op = ALU_SRL;  end
                    F_SRLV: begin kind = K_ALU; alu_op = ALU_SRL; shamt = a_reg[4:0]; end
                    F_SLTU: begin kind = K_ALU; alu_op = ALU_SLTU; end
                    F_SUBU: begin kind = K_ALU; alu_op = ALU_SUB;  end
                    default: kind = K_NOP;
                endcase
            end
            C_ADDIU: begin kind = K_ALU;    alu_op = ALU_ADD; src_b = sign_imm; end
            C_LUI:   begin kind = K_ALU;    alu_op = ALU_LUI; src_b = zero_imm; end
            C_ANDI:  begin kind = K_ALU;    alu_op = ALU_AND; src_b = zero_imm; end
            C_BEQ:   begin kind = K_BRANCH; alu_op = ALU_SUB; end
            C_BNE:   begin kind = K_BRANCH; alu_op = ALU_SUB; end
            C_BGEZ:  begin kind = K_BRANCH; alu_op = ALU_SUB; end
            C_LW:    begin kind = K_MEM;    alu_op = ALU_ADD; src_b = sign_imm; end
            C_SW:    begin kind = K_MEM;    alu_op = ALU_ADD; src_b = sign_imm; end
            default: kind = K_NOP;
        endcase
    end

    sm_alu_v2 u_alu (
        .op     (alu_op),
        .srcA   (a_reg),
        .srcB   (src_b),
        .shamt  (shamt),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        taken = 1'b0;
        case (opcode)
            C_BEQ:   taken = alu_zero;
            C_BNE:   taken = !alu_zero;
            C_BGEZ:  taken = !a_reg[31];
            default: taken = 1'b0;
        endcase
    end

    assign wb_data = (opcode == C_LW) ? mdr : alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= PC_RESET;
            ir      <= 32'h0;
            a_reg   <= 32'h0;
            b_reg   <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imAck) begin
                        ir    <= imData;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg <= (rs == 5'd0) ? 32'h0 : rf[rs];
                    b_reg <= (rt == 5'd0) ? 32'h0 : rf[rt];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    case (kind)
                        K_BRANCH: begin
                            pc    <= pc + 32'd1 + (taken ? sign_imm : 32'h0);
                            state <= S_FETCH;
                        end
                        K_MEM:   state <= S_MEM;
                        K_ALU:   state <= S_WB;
                        default: begin
                            pc    <= pc + 32'd1;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmAck) begin
                        if (is_sw) begin
                            pc    <= pc + 32'd1;
                            state <= S_FETCH;
                        end else begin
                            mdr   <= dmRData;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc    <= pc + 32'd1;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Register file is deliberately left unreset; r0 is never written.
    always_ff @(posedge clk) begin
        if (!rst && state == S_WB && dest != 5'd0) begin
            rf[dest] <= wb_data;
        end
    end

    assign regData  = (regAddr == 5'd0) ? pc : rf[regAddr];
    assign imAddr   = pc;
    assign imReq    = (state == S_FETCH) && !rst;
    assign dmReq    = (state == S_MEM) && !rst;
    assign dmWe     = dmReq && is_sw;
    assign dmAddr   = alu_out;
    assign dmWData  = b_reg;
    assign cpuState = state;

`ifdef SM_CPU_MC_INSTRET_EN
    logic [31:0] instret_cnt;
    logic        retire;

    assign retire = (state == S_WB)
                 || (state == S_EXEC && (kind == K_BRANCH || kind == K_NOP))
                 || (state == S_MEM && dmAck && is_sw);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= 32'h0;
        end else if (retire) begin
            instret_cnt <= instret_cnt + 32'd1;
        end
    end

    assign instRet = instret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm_cpu_mc.sv
`default_nettype none
// tb_sm_cpu_mc : random programs run against an instruction-level model with random
//                memory latency, followed by a reset issued in the middle of a store.
module tb_sm_cpu_mc;

    localparam int PROG_LEN = 84;
    localparam int INIT_LEN = 14;

    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LUI = 6'h0f, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BGEZ = 6'h01;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_OR = 6'h25, FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SLTU = 6'h2b, FN_SUBU = 6'h23;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  regAddr = 5'd0;
    logic [31:0] regData, imAddr, dmAddr, dmWData;
    logic [31:0] imData = 32'h0;
    logic [31:0] dmRData = 32'h0;
    logic        imReq, dmReq, dmWe;
    logic        imAck = 1'b0;
    logic        dmAck = 1'b0;
    logic [2:0]  cpuState;
`ifdef SM_CPU_MC_INSTRET_EN
    logic [31:0] instRet;
`endif

    sm_cpu_mc dut (
        .clk      (clk),
        .rst      (rst),
        .regAddr  (regAddr),
        .regData  (regData),
        .imAddr   (imAddr),
        .imReq    (imReq),
        .imAck    (imAck),
        .imData   (imData),
        .dmAddr   (dmAddr),
        .dmReq    (dmReq),
        .dmWe     (dmWe),
        .dmWData  (dmWData),
        .dmAck    (dmAck),
        .dmRData  (dmRData),
        .cpuState (cpuState)
`ifdef SM_CPU_MC_INSTRET_EN
        ,
        .instRet  (instRet)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } dacc_t;

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:255];
    logic [31:0] mmem [0:255];
    logic [31:0] mreg [0:31];
    logic [31:0] fetch_q [$];
    dacc_t       dacc_q [$];

    int checks = 0;
    int passed = 0;
    int n_model = 0;
    logic mon_en = 1'b0;
    logic done = 1'b0;
    logic im_hold = 1'b0;
    logic dm_hold = 1'b0;
    logic dm_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic gen_program();
        logic [4:0]  a, b, d, sh;
        logic [15:0] imm;
        for (int i = 1; i < 8; i++) begin
            imem[2*i-2] = itype(OP_LUI, 5'd0, 5'(i), 16'($urandom));
            imem[2*i-1] = itype(OP_ADDIU, 5'(i), 5'(i), 16'($urandom));
        end
        for (int p = INIT_LEN; p < PROG_LEN; p++) begin
            a   = 5'($urandom_range(0, 7));
            b   = ($urandom_range(0, 5) == 0) ? a : 5'($urandom_range(0, 7));
            d   = 5'($urandom_range(0, 7));
            sh  = 5'($urandom);
            imm = 16'($urandom);
            case ($urandom_range(0, 15))
                0:  imem[p] = rtype(a, b, d, sh, FN_ADDU);
                1:  imem[p] = rtype(a, b, d, sh, FN_OR);
                2:  imem[p] = rtype(a, b, d, sh, FN_SRL);
                3:  imem[p] = rtype(a, b, d, sh, FN_SRLV);
                4:  imem[p] = rtype(a, b, d, sh, FN_SLTU);
                5:  imem[p] = rtype(a, b, d, sh, FN_SUBU);
                6:  imem[p] = itype(OP_ADDIU, a, b, imm);
                7:  imem[p] = itype(OP_LUI, a, b, imm);
                8:  imem[p] = itype(OP_ANDI, a, b, imm);
                9:  imem[p] = itype(OP_BEQ, a, b, 16'($urandom_range(0, 3)));
                10: imem[p] = itype(OP_BNE, a, b, 16'($urandom_range(0, 3)));
                11: imem[p] = itype(OP_BGEZ, a, 5'd1, 16'($urandom_range(0, 3)));
                12: imem[p] = itype(OP_LW, a, b, imm);
                13: imem[p] = itype(OP_SW, a, b, imm);
                14: imem[p] = itype(6'h3f, a, b, imm);
                default: imem[p] = rtype(a, b, d, sh, 6'h3f);
            endcase
        end
    endtask

    task automatic setr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) mreg[r] = v;
    endtask

    // Instruction-set interpreter: one loop iteration per retired instruction.
    task automatic run_model(output int n);
        logic [31:0] pc, ins, sx, zx, addr, nxt, va, vb;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        dacc_t       e;
        pc = 32'h0;
        n  = 0;
        for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
        for (int k = 0; k < 256; k++) mmem[k] = dmem[k];
        while (pc < 32'(PROG_LEN)) begin
            fetch_q.push_back(pc);
            ins = imem[pc[6:0]];
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
            rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
            sx = 32'($signed(ins[15:0]));
            zx = 32'(ins[15:0]);
            va = mreg[rs];
            vb = mreg[rt];
            nxt = pc + 1;
            addr = va + sx;
            case (op)
                6'h00: case (fn)
                    FN_ADDU: setr(rd, va + vb);
                    FN_OR:   setr(rd, va | vb);
                    FN_SRL:  setr(rd, vb >> sh);
                    FN_SRLV: setr(rd, vb >> (va % 32));
                    FN_SLTU: setr(rd, (va < vb) ? 32'd1 : 32'd0);
                    FN_SUBU: setr(rd, va - vb);
                    default: ;
                endcase
                OP_ADDIU: setr(rt, va + sx);
                OP_LUI:   setr(rt, zx * 32'd65536);
                OP_ANDI:  setr(rt, va & zx);
                OP_BEQ:   if (va == vb) nxt = pc + 1 + sx;
                OP_BNE:   if (va != vb) nxt = pc + 1 + sx;
                OP_BGEZ:  if ($signed(va) >= 0) nxt = pc + 1 + sx;
                OP_LW: begin
                    e.addr = addr; e.we = 1'b0; e.wdata = 32'h0;
                    dacc_q.push_back(e);
                    setr(rt, mmem[addr[7:0]]);
                end
                OP_SW: begin
                    e.addr = addr; e.we = 1'b1; e.wdata = vb;
                    dacc_q.push_back(e);
                    mmem[addr[7:0]] = vb;
                end
                default: ;
            endcase
            n++;
            pc = nxt;
        end
        fetch_q.push_back(pc);
    endtask

    // Memory responder with random wait states; data is garbage except on ack.
    initial begin
        int im_wait, dm_wait;
        im_wait = $urandom_range(0, 3);
        dm_wait = $urandom_range(0, 3);
        forever begin
            @(negedge clk);
            imAck  = 1'b0;
            imData = $urandom;
            if (imReq && !im_hold) begin
                if (im_wait == 0) begin
                    imAck   = 1'b1;
                    imData  = (imAddr < 32'(PROG_LEN)) ? imem[imAddr[6:0]] : 32'h0;
                    im_wait = $urandom_range(0, 3);
                end else begin
                    im_wait--;
                end
            end
            dmAck   = dm_force;
            dmRData = $urandom;
            if (dmReq && !dm_hold) begin
                if (dm_wait == 0) begin
                    dmAck = 1'b1;
                    if (dmWe) dmem[dmAddr[7:0]] = dmWData;
                    else      dmRData = dmem[dmAddr[7:0]];
                    dm_wait = $urandom_range(0, 3);
                end else begin
                    dm_wait--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever a handshake completes.
    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_wait;
        dacc_t       e;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && imReq && prev_wait) chk("imAddr_stable", imAddr, prev_addr);
            prev_wait = imReq && !imAck;
            prev_addr = imAddr;
            if (mon_en && imReq && imAck) begin
                if (fetch_q.size() == 0) begin
                    fail_now("fetch_unexpected");
                end else begin
                    exp_pc = fetch_q.pop_front();
                    chk("fetch_pc", imAddr, exp_pc);
                    if (fetch_q.size() == 0) begin
                        chk("dm_accesses_left", 32'(dacc_q.size()), 32'd0);
`ifdef SM_CPU_MC_INSTRET_EN
                        chk("instRet_run", instRet, 32'(n_model));
`endif
                        mon_en = 1'b0;
                        done   = 1'b1;
                    end
                end
            end
            if (mon_en && dmReq && dmAck) begin
                if (dacc_q.size() == 0) begin
                    fail_now("dm_unexpected");
                end else begin
                    e = dacc_q.pop_front();
                    chk("dmAddr", dmAddr, e.addr);
                    chk("dmWe", 32'(dmWe), 32'(e.we));
                    if (e.we) chk("dmWData", dmWData, e.wdata);
                end
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < 256; k++) dmem[k] = $urandom;
        for (int k = 0; k < 128; k++) imem[k] = 32'h0;
        gen_program();
        run_model(n_model);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_imReq", 32'(imReq), 32'd0);
        chk("rst_dmReq", 32'(dmReq), 32'd0);
        chk("rst_state", 32'(cpuState), 32'd0);
        chk("rst_pc", regData, 32'h0);
`ifdef SM_CPU_MC_INSTRET_EN
        chk("rst_instRet", instRet, 32'h0);
`endif
        mon_en = 1'b1;
        rst    = 1'b0;

        guard = 0;
        while (!done && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!done) fail_now("run_timeout");
        #2;
        for (int r = 1; r < 8; r++) begin
            regAddr = 5'(r);
            #1;
            chk($sformatf("reg_r%0d", r), regData, mreg[r]);
        end
        regAddr = 5'd0;

        // Reset in the middle of a store that is never acknowledged.
        @(negedge clk);
        rst     = 1'b1;
        dm_hold = 1'b1;
        imem[0] = itype(OP_SW, 5'd2, 5'd1, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        while (!dmReq && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!dmReq) fail_now("mem_timeout");
        chk("sw_dmWe", 32'(dmWe), 32'd1);
        chk("sw_dmAddr", dmAddr, mreg[2]);
        chk("sw_dmWData", dmWData, mreg[1]);
        @(negedge clk);
        #1;
        chk("sw_held_dmReq", 32'(dmReq), 32'd1);
        chk("sw_held_dmAddr", dmAddr, mreg[2]);
        rst = 1'b1;
        #1;
        chk("rstmem_dmReq", 32'(dmReq), 32'd0);
        chk("rstmem_dmWe", 32'(dmWe), 32'd0);
        im_hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmem_state", 32'(cpuState), 32'd0);
        chk("rstmem_pc", regData, 32'h0);
`ifdef SM_CPU_MC_INSTRET_EN
        chk("rstmem_instRet", instRet, 32'h0);
`endif
        dm_force = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        dm_force = 1'b0;
        @(negedge clk);
        #1;
        chk("late_ack_state", 32'(cpuState), 32'd0);
        chk("late_ack_pc", regData, 32'h0);
        chk("late_ack_imReq", 32'(imReq), 32'd1);
        chk("late_ack_dmReq", 32'(dmReq), 32'd0);
`ifdef SM_CPU_MC_INSTRET_EN
        chk("late_ack_instRet", instRet, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
